// File: rtl/measurement_shot_histogram_pkg.sv
// -----------------------------------------------------------------------------
// qeip_meas_pkg
// Shared definitions for the measurement shot histogram:
//   - meas_state_e : controller state encoding (IDLE, CLEAR, COLLECT, SCAN, DONE)
//   - num_weight() : number of histogram bins for a given basis-state width
//   - count_width_ok() : legality of the bin/shot counter width for a shot count
// -----------------------------------------------------------------------------
package qeip_meas_pkg;

   typedef enum logic [2:0] {
      IDLE    = 3'd0,
      CLEAR   = 3'd1,
      COLLECT = 3'd2,
      SCAN    = 3'd3,
      DONE    = 3'd4
   } meas_state_e;

   // One bin per basis state.
   function automatic int num_weight(input int num_qubit);
      return 1 << num_qubit;
   endfunction

   // The counter must be able to hold NUM_SHOT without wrapping, and a run
   // must contain at least one shot so the argmax scan always finds a bin.
   function automatic bit count_width_ok(input int count_width, input int num_shot);
      if (num_shot < 1) return 1'b0;
      if (count_width >= 32) return 1'b1;
      return (longint'(1) << count_width) > longint'(num_shot);
   endfunction

endpackage

// File: rtl/measurement_shot_histogram_shot_bin_file.sv
// -----------------------------------------------------------------------------
// shot_bin_file
// NUM_WEIGHT x COUNT_WIDTH histogram register array.
// Ports:
//   clk, rstnn            : clock, asynchronous active-low reset (bins -> 0)
//   clear                 : synchronous clear of every bin (wins over inc_en)
//   inc_en, inc_idx       : saturating +1 of bin inc_idx
//   rd_addr -> rd_count   : registered read port, 1-cycle latency; a read of a
//                           bin being incremented returns the old value
//   scan_idx -> scan_count: combinational read used by the argmax scan
// -----------------------------------------------------------------------------
module shot_bin_file
   import qeip_meas_pkg::*;
#(
   parameter int NUM_QUBIT   = 4,
   parameter int COUNT_WIDTH = 16
) (
   input  logic                   clk,
   input  logic                   rstnn,
   input  logic                   clear,
   input  logic                   inc_en,
   input  logic [NUM_QUBIT-1:0]   inc_idx,
   input  logic [NUM_QUBIT-1:0]   rd_addr,
   output logic [COUNT_WIDTH-1:0] rd_count,
   input  logic [NUM_QUBIT-1:0]   scan_idx,
   output logic [COUNT_WIDTH-1:0] scan_count
);

   localparam int NUM_WEIGHT = num_weight(NUM_QUBIT);

   logic [COUNT_WIDTH-1:0] bins_q [NUM_WEIGHT];
   logic [COUNT_WIDTH-1:0] bins_d [NUM_WEIGHT];
   logic [COUNT_WIDTH-1:0] rd_count_q;
   logic [COUNT_WIDTH-1:0] rd_count_d;

   always_comb begin
      bins_d = bins_q;
      if (clear) begin
         for (int i = 0; i < NUM_WEIGHT; i++) begin
            bins_d[i] = '0;
         end
      end else if (inc_en && (bins_q[inc_idx] != '1)) begin
         // Saturate instead of wrapping so a bad configuration cannot make a
         // heavy bin look light.
         bins_d[inc_idx] = bins_q[inc_idx] + COUNT_WIDTH'(1);
      end
      // Read uses the current register contents, hence pre-increment data.
      rd_count_d = bins_q[rd_addr];
   end

   always_ff @(posedge clk or negedge rstnn) begin
      if (!rstnn) begin
         for (int i = 0; i < NUM_WEIGHT; i++) begin
            bins_q[i] <= '0;
         end
         rd_count_q <= '0;
      end else begin
         bins_q     <= bins_d;
         rd_count_q <= rd_count_d;
      end
   end

   assign rd_count   = rd_count_q;
   assign scan_count = bins_q[scan_idx];

endmodule

// File: rtl/measurement_shot_histogram.sv
// -----------------------------------------------------------------------------
// measurement_shot_histogram
// Bins NUM_SHOT basis-state samples into per-state counters, then scans the
// bins and reports the most frequent state (lowest index on ties).
// Ports:
//   clk, rstnn              : clock, asynchronous active-low reset
//   start                   : single-cycle run request (honoured in IDLE only)
//   sample, sample_stb      : basis-state sample and its valid strobe; counted
//                             only in COLLECT
//   busy                    : high whenever the controller is not IDLE
//   done                    : one-cycle pulse, best_state/best_count valid
//   best_state, best_count  : argmax bin and its count of the last finished run
//   rd_addr -> rd_count     : registered histogram read, 1-cycle latency
// Handshake: sample is consumed on every clock edge where sample_stb=1 and the
// controller is in COLLECT; there is no back-pressure, strobes elsewhere are
// dropped.
// -----------------------------------------------------------------------------
module measurement_shot_histogram
   import qeip_meas_pkg::*;
#(
   parameter int NUM_QUBIT   = 4,
   parameter int NUM_SHOT    = 1024,
   parameter int COUNT_WIDTH = 16
) (
   input  logic                   clk,
   input  logic                   rstnn,
   input  logic                   start,
   input  logic [NUM_QUBIT-1:0]   sample,
   input  logic                   sample_stb,
   output logic                   busy,
   output logic                   done,
   output logic [NUM_QUBIT-1:0]   best_state,
   output logic [COUNT_WIDTH-1:0] best_count,
   input  logic [NUM_QUBIT-1:0]   rd_addr,
   output logic [COUNT_WIDTH-1:0] rd_count
);

   localparam int NUM_WEIGHT = num_weight(NUM_QUBIT);
   localparam logic [COUNT_WIDTH-1:0] SHOT_LAST = COUNT_WIDTH'(NUM_SHOT);
   localparam logic [NUM_QUBIT-1:0]   IDX_LAST  = NUM_QUBIT'(NUM_WEIGHT - 1);

   if (!count_width_ok(COUNT_WIDTH, NUM_SHOT)) begin : g_bad_cfg
      $error("measurement_shot_histogram: COUNT_WIDTH too small for NUM_SHOT");
   end

   meas_state_e            state_q,      state_d;
   logic [COUNT_WIDTH-1:0] shot_cnt_q,   shot_cnt_d;
   logic [NUM_QUBIT-1:0]   scan_idx_q,   scan_idx_d;
   logic [COUNT_WIDTH-1:0] max_count_q,  max_count_d;
   logic [NUM_QUBIT-1:0]   max_state_q,  max_state_d;
   logic [COUNT_WIDTH-1:0] best_count_q, best_count_d;
   logic [NUM_QUBIT-1:0]   best_state_q, best_state_d;

   logic                   bin_clear;
   logic                   bin_inc;
   logic [COUNT_WIDTH-1:0] scan_count;
   logic                   scan_hit;
   logic [COUNT_WIDTH-1:0] cand_count;
   logic [NUM_QUBIT-1:0]   cand_state;

   shot_bin_file #(
      .NUM_QUBIT   (NUM_QUBIT),
      .COUNT_WIDTH (COUNT_WIDTH)
   ) u_bins (
      .clk        (clk),
      .rstnn      (rstnn),
      .clear      (bin_clear),
      .inc_en     (bin_inc),
      .inc_idx    (sample),
      .rd_addr    (rd_addr),
      .rd_count   (rd_count),
      .scan_idx   (scan_idx_q),
      .scan_count (scan_count)
   );

   // Strict compare: an equal later bin never displaces an earlier one, so
   // ties resolve to the lowest index.
   assign scan_hit   = scan_count > max_count_q;
   assign cand_count = scan_hit ? scan_count : max_count_q;
   assign cand_state = scan_hit ? scan_idx_q : max_state_q;

   always_comb begin
      state_d      = state_q;
      shot_cnt_d   = shot_cnt_q;
      scan_idx_d   = scan_idx_q;
      max_count_d  = max_count_q;
      max_state_d  = max_state_q;
      best_count_d = best_count_q;
      best_state_d = best_state_q;
      bin_clear    = 1'b0;
      bin_inc      = 1'b0;

      case (state_q)
         IDLE: begin
            if (start) state_d = CLEAR;
         end
         CLEAR: begin
            // best_* deliberately survive so the previous answer stays
            // readable until this run's scan finishes.
            bin_clear   = 1'b1;
            shot_cnt_d  = '0;
            scan_idx_d  = '0;
            max_count_d = '0;
            max_state_d = '0;
            state_d     = COLLECT;
         end
         COLLECT: begin
            if (sample_stb) begin
               bin_inc    = 1'b1;
               shot_cnt_d = shot_cnt_q + COUNT_WIDTH'(1);
               if (shot_cnt_d == SHOT_LAST) state_d = SCAN;
            end
         end
         SCAN: begin
            max_count_d = cand_count;
            max_state_d = cand_state;
            scan_idx_d  = scan_idx_q + NUM_QUBIT'(1);
            if (scan_idx_q == IDX_LAST) begin
               best_count_d = cand_count;
               best_state_d = cand_state;
               state_d      = DONE;
            end
         end
         DONE: begin
            state_d = IDLE;
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

   always_ff @(posedge clk or negedge rstnn) begin
      if (!rstnn) begin
         state_q      <= IDLE;
         shot_cnt_q   <= '0;
         scan_idx_q   <= '0;
         max_count_q  <= '0;
         max_state_q  <= '0;
         best_count_q <= '0;
         best_state_q <= '0;
      end else begin
         state_q      <= state_d;
         shot_cnt_q   <= shot_cnt_d;
         scan_idx_q   <= scan_idx_d;
         max_count_q  <= max_count_d;
         max_state_q  <= max_state_d;
         best_count_q <= best_count_d;
         best_state_q <= best_state_d;
      end
   end

   assign busy       = (state_q != IDLE);
   assign done       = (state_q == DONE);
   assign best_state = best_state_q;
   assign best_count = best_count_q;

endmodule

// File: tb/tb_measurement_shot_histogram.sv
module tb_measurement_shot_histogram;

   localparam int NQ = 4;
   localparam int NS = 8;
   localparam int CW = 16;
   localparam int NW = 16;

   // ---------------- clock / reset ----------------
   logic          clk = 1'b0;
   logic          rstnn = 1'b0;
   logic          start = 1'b0;
   logic [NQ-1:0] sample = '0;
   logic          sample_stb = 1'b0;
   logic          busy;
   logic          done;
   logic [NQ-1:0] best_state;
   logic [CW-1:0] best_count;
   logic [NQ-1:0] rd_addr = '0;
   logic [CW-1:0] rd_count;

   always #5 clk = ~clk;

   measurement_shot_histogram #(
      .NUM_QUBIT   (NQ),
      .NUM_SHOT    (NS),
      .COUNT_WIDTH (CW)
   ) dut (
      .clk        (clk),
      .rstnn      (rstnn),
      .start      (start),
      .sample     (sample),
      .sample_stb (sample_stb),
      .busy       (busy),
      .done       (done),
      .best_state (best_state),
      .best_count (best_count),
      .rd_addr    (rd_addr),
      .rd_count   (rd_count)
   );

   // ---------------- scoreboard ----------------
   int n_checks = 0;
   int n_errors = 0;
   int done_seen = 0;
   logic [NQ+CW-1:0] exp_q[$];
   int model_hist [NW];
   logic [NQ-1:0] last_state = '0;
   logic [CW-1:0] last_count = '0;

   always @(negedge clk) if (rstnn && done) done_seen++;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0d expected %0d", name, act, exp);
      end
   endtask

   // Reference: histogram of the shots, the largest count, and the first
   // state holding that count.
   function automatic logic [NQ+CW-1:0] model_best(input logic [31:0] sv);
      int h [NW];
      int mx;
      int idx;
      for (int i = 0; i < NW; i++) h[i] = 0;
      for (int i = 0; i < NS; i++) h[sv[i*4 +: 4]]++;
      mx = 0;
      for (int i = 0; i < NW; i++) if (h[i] > mx) mx = h[i];
      idx = 0;
      for (int i = NW - 1; i >= 0; i--) if (h[i] == mx) idx = i;
      return {NQ'(idx), CW'(mx)};
   endfunction

   // ---------------- driver ----------------
   // sv holds shot i in bits [4i+3:4i]. noise adds stray strobes in IDLE/CLEAR,
   // a start in COLLECT, strobes during SCAN and a start in the DONE cycle.
   task automatic do_run(input logic [31:0] sv, input int gap, input bit noise,
                         input logic [NQ+CW-1:0] expect_best);
      logic [NQ-1:0] smp;
      logic [NQ+CW-1:0] got;
      int k;
      int sum;
      int d0;
      d0 = done_seen;
      for (int i = 0; i < NW; i++) model_hist[i] = 0;
      exp_q.push_back(expect_best);

      @(posedge clk); #1;
      start = 1'b1;
      if (noise) begin sample_stb = 1'b1; sample = 4'd1; end
      @(posedge clk); #1;                 // E0: now in CLEAR
      start = 1'b0;
      check("busy_after_start", busy, 1);
      @(posedge clk); #1;                 // E0+1: now in COLLECT
      sample_stb = 1'b0;

      for (int i = 0; i < NS; i++) begin
         smp = sv[i*4 +: 4];
         repeat (gap) begin @(posedge clk); #1; end
         if (noise && i == 3) begin
            start = 1'b1;
            @(posedge clk); #1;
            start = 1'b0;
         end
         sample = smp;
         sample_stb = 1'b1;
         rd_addr = smp;
         @(posedge clk); #1;
         sample_stb = 1'b0;
         check("rd_pre_increment", rd_count, model_hist[smp]);
         model_hist[smp]++;
      end

      check("best_state_hold", best_state, last_state);
      check("best_count_hold", best_count, last_count);

      k = 0;
      while (!done && k < 40) begin
         if (noise) begin sample_stb = 1'b1; sample = NQ'($urandom_range(0, 15)); end
         @(posedge clk); #1;
         k++;
      end
      sample_stb = 1'b0;
      check("done_latency", k, NW);
      check("done_high", done, 1);
      if (exp_q.size() > 0) begin
         got = exp_q.pop_front();
         check("best_state", best_state, got[NQ+CW-1:CW]);
         check("best_count", best_count, got[CW-1:0]);
         last_state = got[NQ+CW-1:CW];
         last_count = got[CW-1:0];
      end
      if (noise) start = 1'b1;            // must be ignored in DONE
      @(posedge clk); #1;
      start = 1'b0;
      check("done_pulse_width", done, 0);
      check("busy_fall", busy, 0);
      @(posedge clk); #1;
      check("no_restart_from_done", busy, 0);
      check("done_count", done_seen - d0, 1);

      sum = 0;
      for (int a = 0; a < NW; a++) begin
         rd_addr = NQ'(a);
         @(posedge clk); #1;
         check("hist_bin", rd_count, model_hist[a]);
         sum += int'(rd_count);
      end
      check("hist_sum", sum, NS);
      check("best_hold_after", best_count, last_count);
   endtask

   // ---------------- test table ----------------
   typedef struct packed {
      logic [31:0]   shots;
      logic [3:0]    gap;
      logic          noise;
      logic [NQ-1:0] exp_state;
      logic [CW-1:0] exp_count;
   } vec_t;

   vec_t vecs [5];

   initial begin : watchdog
      #2000000;
      $display("FAIL watchdog: simulation time limit reached");
      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors + 1);
      $fatal(1, "timeout");
   end

   initial begin : main
      logic [31:0] rsv;
      int d0;

      vecs[0] = '{shots: 32'h55555555, gap: 4'd0, noise: 1'b0, exp_state: 4'd5,  exp_count: 16'd8};
      vecs[1] = '{shots: 32'hCCCCCCCC, gap: 4'd0, noise: 1'b0, exp_state: 4'd12, exp_count: 16'd8};
      vecs[2] = '{shots: 32'h93199933, gap: 4'd2, noise: 1'b0, exp_state: 4'd9,  exp_count: 16'd4};
      vecs[3] = '{shots: 32'h72727272, gap: 4'd1, noise: 1'b0, exp_state: 4'd2,  exp_count: 16'd4};
      vecs[4] = '{shots: 32'h0F0F3F0F, gap: 4'd1, noise: 1'b1, exp_state: 4'd15, exp_count: 16'd4};

      // reset state
      #1;
      check("rst_busy", busy, 0);
      check("rst_done", done, 0);
      check("rst_best_state", best_state, 0);
      check("rst_best_count", best_count, 0);
      check("rst_rd_count", rd_count, 0);
      repeat (3) @(posedge clk);
      #1 rstnn = 1'b1;
      // strobes in IDLE must not count
      sample = 4'd3; sample_stb = 1'b1;
      repeat (3) @(posedge clk);
      #1 sample_stb = 1'b0;

      for (int v = 0; v < 5; v++) begin
         do_run(vecs[v].shots, int'(vecs[v].gap), vecs[v].noise,
                {vecs[v].exp_state, vecs[v].exp_count});
      end

      // reset in the middle of COLLECT
      d0 = done_seen;
      @(posedge clk); #1 start = 1'b1;
      @(posedge clk); #1 start = 1'b0;
      @(posedge clk); #1;
      for (int i = 0; i < 5; i++) begin
         sample = NQ'($urandom_range(0, 15)); sample_stb = 1'b1;
         @(posedge clk); #1 sample_stb = 1'b0;
      end
      check("mid_run_busy", busy, 1);
      rstnn = 1'b0;
      #1;
      check("abort_busy", busy, 0);
      check("abort_done", done, 0);
      check("abort_best_state", best_state, 0);
      check("abort_best_count", best_count, 0);
      check("abort_rd_count", rd_count, 0);
      repeat (2) @(posedge clk);
      #1 rstnn = 1'b1;
      last_state = '0;
      last_count = '0;
      for (int a = 0; a < NW; a++) begin
         rd_addr = NQ'(a);
         @(posedge clk); #1;
         check("abort_bin_zero", rd_count, 0);
      end
      check("abort_no_done", done_seen - d0, 0);

      // randomized runs against the reference model
      for (int r = 0; r < 8; r++) begin
         rsv = $urandom;
         if (r == 0) rsv = {8{NQ'($urandom_range(0, 15))}};
         do_run(rsv, $urandom_range(0, 2), r[0], model_best(rsv));
      end

      check("exp_q_empty", exp_q.size(), 0);
      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule

// File: doc/measurement_shot_histogram.md
# measurement_shot_histogram

Downstream consumer of the weighted sampler in the Grover measurement path. Accepts one NUM_QUBIT-bit basis-state sample per `sample_stb`, bins NUM_SHOT consecutive samples into per-state counters, then scans the bins and reports the most frequent state and its count. Gives software/host a single measured answer plus a readable histogram per run.

## Interface
- NUM_QUBIT, 4, basis-state width; NUM_WEIGHT = 2**NUM_QUBIT bins
- NUM_SHOT, 1024, samples collected per run (>= 1)
- COUNT_WIDTH, 16, bin/shot counter width; must satisfy 2**COUNT_WIDTH > NUM_SHOT
- clk  in  1  clock
- rstnn  in  1  reset; asynchronous, active-low
- start  in  1  single-cycle run request
- sample  in  NUM_QUBIT  sampled basis state from the weighted sampler
- sample_stb  in  1  `sample` valid this cycle
- busy  out  1  high in every state except IDLE
- done  out  1  one-cycle pulse: result valid
- best_state  out  NUM_QUBIT  argmax bin index of last completed run
- best_count  out  COUNT_WIDTH  count in best_state bin
- rd_addr  in  NUM_QUBIT  histogram read address
- rd_count  out  COUNT_WIDTH  registered count of bin rd_addr

## Operation
- States: IDLE, CLEAR, COLLECT, SCAN, DONE.
- IDLE: `start`=1 -> CLEAR. Samples ignored.
- CLEAR (1 cycle): all bins, shot counter, scan index, running max cleared to 0 -> COLLECT. Samples ignored.
- COLLECT: each `sample_stb`=1 increments bin[`sample`] and shot counter. When shot counter reaches NUM_SHOT (edge capturing the NUM_SHOT-th sample) -> SCAN. No `sample_stb` = no change; no timeout.
- SCAN: one bin per cycle, index 0..NUM_WEIGHT-1. Replace running max only if bin > max (strict), so ties resolve to lowest index; all-zero impossible since NUM_SHOT >= 1. After last index -> DONE, best_state/best_count loaded.
- DONE (1 cycle): `done`=1 -> IDLE.
- `start` outside IDLE ignored. `sample_stb` outside COLLECT dropped, not counted.
- Bins saturate at 2**COUNT_WIDTH-1 (defensive; unreachable with legal parameters).
- best_state/best_count hold from DONE until next run's SCAN completes; not cleared by CLEAR.
- Histogram holds after DONE until next CLEAR; readable at any time, live during COLLECT.

## Timing
- Reset: state IDLE, busy 0, done 0, best_state 0, best_count 0, rd_count 0, all bins 0. Reset mid-run aborts; no done issued.
- `start` sampled at edge E0: busy=1 after E0 (CLEAR); COLLECT from edge E0+1; first countable sample at edge E0+2.
- Last sample captured at edge E: SCAN for NUM_WEIGHT cycles; `done` high for exactly the cycle after edge E+NUM_WEIGHT, best_* valid in that same cycle; busy falls after edge E+NUM_WEIGHT+1.
- Minimum run: 2 + NUM_SHOT + NUM_WEIGHT + 1 cycles start-to-idle with back-to-back samples.
- rd_count: 1-cycle latency from rd_addr. Read of bin being incremented in the same cycle returns pre-increment value.
- `start` in the DONE cycle ignored; earliest restart the cycle after busy falls.

## Structure
- Package qeip_meas_pkg: state enum (IDLE, CLEAR, COLLECT, SCAN, DONE), NUM_WEIGHT derivation, COUNT_WIDTH legality check.
- Sub-module shot_bin_file: NUM_WEIGHT x COUNT_WIDTH register array with synchronous clear-all, single-index saturating increment, registered read port. FSM, shot counter, argmax scan in top.

## Test plan
- NUM_QUBIT=4, NUM_SHOT=8; 8 back-to-back samples all 4'd5 -> done once, best_state=5, best_count=8; rd_addr=5 -> rd_count=8, rd_addr=0 -> 0.
- Samples 3,3,9,9,9,1,3,9 with gaps between strobes -> best_state=9, best_count=4; done exactly NUM_WEIGHT=16 cycles after the 8th-sample edge.
- Tie: samples 2,7,2,7,2,7,2,7 -> best_state=2, best_count=4.
- sample_stb pulses during IDLE, CLEAR, SCAN and extra strobes after 8th sample -> ignored; histogram sums to 8; `start` during COLLECT -> no restart.
- rstnn low after 5 samples -> all outputs 0, state IDLE, no done; fresh run then yields correct result.
- Two consecutive runs (all 5, then all 12) -> second result 12/8, bin 5 reads 0 after second CLEAR; best_* hold 5/8 until second DONE.
